parking_gate_ctrl: RTL and testbench
====================================

# parking_gate_ctrl

Clocked, parametrised successor of the two-class (university / guest) parking occupancy counter. It arbitrates one entry gate and one exit gate, admits or refuses each car against an hour-dependent capacity split, and times each barrier opening with a small per-gate state machine. It sits between the gate sensors / hour-of-day source and the occupancy displays, driving both the counts and the vacancy flags.

## Interface

- TOTAL_CAP, 700: total spaces; split between classes by the hour schedule.
- CNT_W, 10: width of occupancy counters; 2**CNT_W > TOTAL_CAP required.
- DAY_START, 8: first hour of the fixed day window.
- RAMP_START, 13: first hour of the guest-capacity ramp.
- RAMP_END, 16: first hour of the night window.
- GUEST_DAY, 200: guest capacity in [DAY_START, RAMP_START).
- GUEST_STEP, 50: guest capacity increment per hour in the ramp.
- GUEST_NIGHT, 500: guest capacity outside [DAY_START, RAMP_END) and for hour > 23.
- OPEN_CYCLES, 4: barrier open time in clocks, ≥ 1.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- hour  in  5  hour of day, 0-23.
- entry_req  in  1  car at entry gate, level; sampled only when the entry FSM is IDLE.
- entry_is_uni  in  1  class of the entering car, 1 = university.
- exit_req  in  1  car at exit gate, level; sampled only when the exit FSM is IDLE.
- exit_is_uni  in  1  class of the exiting car.
- entry_grant  out  1  one-cycle pulse: car admitted.
- entry_deny  out  1  one-cycle pulse: class full, car refused.
- entry_busy  out  1  entry barrier open.
- exit_ack  out  1  one-cycle pulse: exit counted.
- exit_err  out  1  one-cycle pulse: exit of a class with zero count.
- exit_busy  out  1  exit barrier open.
- uni_parked, guest_parked  out  CNT_W  occupancy per class.
- uni_free, guest_free  out  CNT_W+1 signed  capacity minus occupancy; negative when over capacity.
- uni_full, guest_full  out  1  free ≤ 0.
- lot_vacant  out  1  uni_free + guest_free > 0.

## Operation

- Capacity: hour registered (hour_q). guest_cap = GUEST_DAY in the day window, GUEST_DAY + (hour_q − RAMP_START + 1)·GUEST_STEP in the ramp, GUEST_NIGHT otherwise; uni_cap = TOTAL_CAP − guest_cap.
- Each gate has a two-state FSM, IDLE and OPEN, plus a down-timer.
- Entry, IDLE with entry_req=1: if the selected class's free > 0, increment its count, pulse entry_grant, go to OPEN with timer = OPEN_CYCLES−1. Otherwise pulse entry_deny and stay IDLE.
- Exit, IDLE with exit_req=1: if the selected count > 0, decrement it, pulse exit_ack, go to OPEN. Otherwise pulse exit_err and stay IDLE.
- OPEN: busy=1; the timer decrements each clock; at timer=0 the next edge returns to IDLE. Requests in OPEN are ignored (no pulse).
- Admission uses pre-edge counts. An exit in the same cycle does not free a space for that cycle's entry.
- Same-class entry and exit in one cycle both apply; the net count is unchanged.
- Capacity shrink below occupancy (hour change): counts are kept, free goes negative, full=1, and exits proceed normally.
- Counters never wrap: increment is gated by free > 0, and decrement by count > 0.

## Timing

- Reset (async assert, release synchronous to clk): counts 0, hour_q 0 (night: guest_cap 500, uni_cap 200), both FSMs IDLE, all pulses and busy 0, uni_free 200, guest_free 500, full flags 0, lot_vacant 1.
- Reset mid-OPEN aborts the barrier immediately and clears counts.
- Request sampled at edge k: count update, grant/deny/ack/err and busy are all visible after edge k; pulse width is 1 cycle.
- busy is high for exactly OPEN_CYCLES cycles. The earliest next acceptance is at edge k+OPEN_CYCLES+1.
- A held request is re-evaluated each IDLE cycle. A held request on a full class therefore pulses deny every cycle.
- hour change reaches the capacities one edge later; free and full are combinational from the counts and registered caps.

## Test plan

- Reset, hour=10 → after 1 clk: guest_free=200, uni_free=500; entry_req guest 1 cycle → entry_grant pulse, guest_parked=1, entry_busy high 4 cycles.
- hour=10, admit 200 guests, then one more guest entry → entry_deny, guest_parked stays 200, guest_full=1, no busy.
- Guest exit with guest_parked=0 → exit_err pulse, count 0, exit_busy stays 0.
- guest_parked=199, hour=10, simultaneous guest entry and guest exit → grant and ack in the same cycle, guest_parked=199. With guest_parked=200, the same stimulus gives deny and ack, and guest_parked=199.
- hour 20 with uni_parked=300, then hour=20→10 → uni_cap 500, uni_free=200. With uni_parked=300 at hour=20 (uni_cap 200) → uni_free=−100, uni_full=1, uni entry denied, uni exit acked.
- hour 13, 14, 15, 16 → guest_cap 250, 300, 350, 500. hour=31 → guest_cap 500. Assert rst_n=0 mid-OPEN → busy drops and counts are 0 immediately.

Source files
------------

// File: rtl/parking_gate_ctrl.sv
// rtl/parking_gate_ctrl.sv - two-class parking occupancy with entry/exit barrier FSMs
module parking_gate_ctrl #(
    parameter int TOTAL_CAP   = 700,
    parameter int CNT_W       = 10,
    parameter int DAY_START   = 8,
    parameter int RAMP_START  = 13,
    parameter int RAMP_END    = 16,
    parameter int GUEST_DAY   = 200,
    parameter int GUEST_STEP  = 50,
    parameter int GUEST_NIGHT = 500,
    parameter int OPEN_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4:0]              hour,
    input  logic                    entry_req,
    input  logic                    entry_is_uni,
    input  logic                    exit_req,
    input  logic                    exit_is_uni,
    output logic                    entry_grant,
    output logic                    entry_deny,
    output logic                    entry_busy,
    output logic                    exit_ack,
    output logic                    exit_err,
    output logic                    exit_busy,
    output logic [CNT_W-1:0]        uni_parked,
    output logic [CNT_W-1:0]        guest_parked,
    output logic signed [CNT_W:0]   uni_free,
    output logic signed [CNT_W:0]   guest_free,
    output logic                    uni_full,
    output logic                    guest_full,
    output logic                    lot_vacant
);
    // Timer only has to hold OPEN_CYCLES-1; keep at least one bit for OPEN_CYCLES=1.
    localparam int TMR_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

    typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} gate_state_e;

    gate_state_e             ent_state_q, ent_state_d, ext_state_q, ext_state_d;
    logic [TMR_W-1:0]        ent_timer_q, ent_timer_d, ext_timer_q, ext_timer_d;
    logic [CNT_W-1:0]        uni_parked_q, uni_parked_d, guest_parked_q, guest_parked_d;
    logic [4:0]              hour_q, hour_d;
    logic                    entry_grant_q, entry_grant_d, entry_deny_q, entry_deny_d;
    logic                    exit_ack_q, exit_ack_d, exit_err_q, exit_err_d;
    logic                    uni_inc, guest_inc, uni_dec, guest_dec;
    logic [CNT_W-1:0]        guest_cap, uni_cap;
    logic signed [CNT_W+1:0] lot_sum;

    // State register: gate FSMs, timers, counts, registered hour and pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_state_q    <= IDLE;
            ext_state_q    <= IDLE;
            ent_timer_q    <= '0;
            ext_timer_q    <= '0;
            uni_parked_q   <= '0;
            guest_parked_q <= '0;
            hour_q         <= '0;
            entry_grant_q  <= 1'b0;
            entry_deny_q   <= 1'b0;
            exit_ack_q     <= 1'b0;
            exit_err_q     <= 1'b0;
        end else begin
            ent_state_q    <= ent_state_d;
            ext_state_q    <= ext_state_d;
            ent_timer_q    <= ent_timer_d;
            ext_timer_q    <= ext_timer_d;
            uni_parked_q   <= uni_parked_d;
            guest_parked_q <= guest_parked_d;
            hour_q         <= hour_d;
            entry_grant_q  <= entry_grant_d;
            entry_deny_q   <= entry_deny_d;
            exit_ack_q     <= exit_ack_d;
            exit_err_q     <= exit_err_d;
        end
    end

    // Next state: admission/exit decisions on pre-edge counts, barrier timing
    always_comb begin
        ent_state_d   = ent_state_q;
        ent_timer_d   = ent_timer_q;
        ext_state_d   = ext_state_q;
        ext_timer_d   = ext_timer_q;
        entry_grant_d = 1'b0;
        entry_deny_d  = 1'b0;
        exit_ack_d    = 1'b0;
        exit_err_d    = 1'b0;
        uni_inc       = 1'b0;
        guest_inc     = 1'b0;
        uni_dec       = 1'b0;
        guest_dec     = 1'b0;
        hour_d        = hour;

        case (ent_state_q)
            IDLE: begin
                if (entry_req) begin
                    if (entry_is_uni ? !uni_full : !guest_full) begin
                        entry_grant_d = 1'b1;
                        uni_inc       = entry_is_uni;
                        guest_inc     = !entry_is_uni;
                        ent_state_d   = OPEN;
                        ent_timer_d   = TMR_W'(OPEN_CYCLES - 1);
                    end else begin
                        entry_deny_d  = 1'b1;
                    end
                end
            end
            default: begin
                if (ent_timer_q == '0) ent_state_d = IDLE;
                else                   ent_timer_d = ent_timer_q - 1'b1;
            end
        endcase

        case (ext_state_q)
            IDLE: begin
                if (exit_req) begin
                    if (exit_is_uni ? (uni_parked_q != '0) : (guest_parked_q != '0)) begin
                        exit_ack_d  = 1'b1;
                        uni_dec     = exit_is_uni;
                        guest_dec   = !exit_is_uni;
                        ext_state_d = OPEN;
                        ext_timer_d = TMR_W'(OPEN_CYCLES - 1);
                    end else begin
                        exit_err_d  = 1'b1;
                    end
                end
            end
            default: begin
                if (ext_timer_q == '0) ext_state_d = IDLE;
                else                   ext_timer_d = ext_timer_q - 1'b1;
            end
        endcase

        uni_parked_d   = uni_parked_q + CNT_W'(uni_inc) - CNT_W'(uni_dec);
        guest_parked_d = guest_parked_q + CNT_W'(guest_inc) - CNT_W'(guest_dec);
    end

    // Outputs: busy from FSM state, capacity split from hour_q, free/full/vacancy
    always_comb begin
        entry_busy = (ent_state_q == OPEN);
        exit_busy  = (ext_state_q == OPEN);

        if (hour_q >= 5'(DAY_START) && hour_q < 5'(RAMP_START))
            guest_cap = CNT_W'(GUEST_DAY);
        else if (hour_q >= 5'(RAMP_START) && hour_q < 5'(RAMP_END))
            guest_cap = CNT_W'(GUEST_DAY + (int'(hour_q) - RAMP_START + 1) * GUEST_STEP);
        else
            guest_cap = CNT_W'(GUEST_NIGHT);
        uni_cap = CNT_W'(TOTAL_CAP) - guest_cap;

        uni_free   = $signed({1'b0, uni_cap}) - $signed({1'b0, uni_parked_q});
        guest_free = $signed({1'b0, guest_cap}) - $signed({1'b0, guest_parked_q});
        uni_full   = uni_free[CNT_W] || (uni_free == '0);
        guest_full = guest_free[CNT_W] || (guest_free == '0);

        lot_sum    = $signed({uni_free[CNT_W], uni_free}) + $signed({guest_free[CNT_W], guest_free});
        lot_vacant = !lot_sum[CNT_W+1] && (lot_sum != '0);
    end

    assign entry_grant  = entry_grant_q;
    assign entry_deny   = entry_deny_q;
    assign exit_ack     = exit_ack_q;
    assign exit_err     = exit_err_q;
    assign uni_parked   = uni_parked_q;
    assign guest_parked = guest_parked_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb/tb_parking_gate_ctrl.sv - directed and randomized checks against a behavioural lot model
module tb_parking_gate_ctrl;
    localparam int TOTAL = 700;
    localparam int OC    = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [4:0]        hour = '0;
    logic              entry_req = 1'b0, entry_is_uni = 1'b0;
    logic              exit_req = 1'b0, exit_is_uni = 1'b0;
    logic              entry_grant, entry_deny, entry_busy;
    logic              exit_ack, exit_err, exit_busy;
    logic [9:0]        uni_parked, guest_parked;
    logic signed [10:0] uni_free, guest_free;
    logic              uni_full, guest_full, lot_vacant;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int m_hour, m_uni, m_guest, m_ent_rem, m_ext_rem;
    bit m_grant, m_deny, m_ack, m_err;

    parking_gate_ctrl dut (
        .clk(clk), .rst_n(rst_n), .hour(hour),
        .entry_req(entry_req), .entry_is_uni(entry_is_uni),
        .exit_req(exit_req), .exit_is_uni(exit_is_uni),
        .entry_grant(entry_grant), .entry_deny(entry_deny), .entry_busy(entry_busy),
        .exit_ack(exit_ack), .exit_err(exit_err), .exit_busy(exit_busy),
        .uni_parked(uni_parked), .guest_parked(guest_parked),
        .uni_free(uni_free), .guest_free(guest_free),
        .uni_full(uni_full), .guest_full(guest_full), .lot_vacant(lot_vacant)
    );

    always #5 clk = ~clk;

    function automatic int guest_cap_of(input int h);
        if (h >= 8 && h <= 12)  return 200;
        if (h >= 13 && h <= 15) return 200 + (h - 12) * 50;
        return 500;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int gcap;
        gcap = guest_cap_of(m_hour);
        check("entry_grant", 32'(entry_grant), 32'(m_grant));
        check("entry_deny",  32'(entry_deny),  32'(m_deny));
        check("entry_busy",  32'(entry_busy),  32'(m_ent_rem > 0));
        check("exit_ack",    32'(exit_ack),    32'(m_ack));
        check("exit_err",    32'(exit_err),    32'(m_err));
        check("exit_busy",   32'(exit_busy),   32'(m_ext_rem > 0));
        check("uni_parked",  32'(uni_parked),  m_uni);
        check("guest_parked",32'(guest_parked),m_guest);
        check("uni_free",    32'(uni_free),    (TOTAL - gcap) - m_uni);
        check("guest_free",  32'(guest_free),  gcap - m_guest);
        check("uni_full",    32'(uni_full),    32'((TOTAL - gcap) - m_uni <= 0));
        check("guest_full",  32'(guest_full),  32'(gcap - m_guest <= 0));
        check("lot_vacant",  32'(lot_vacant),  32'(TOTAL - m_uni - m_guest > 0));
    endtask

    task automatic model_reset();
        m_hour = 0; m_uni = 0; m_guest = 0; m_ent_rem = 0; m_ext_rem = 0;
        m_grant = 0; m_deny = 0; m_ack = 0; m_err = 0;
    endtask

    // one clock: model decides from pre-edge state, then DUT is sampled 1 time unit after the edge
    task automatic step();
        int gcap, ucap, n_uni, n_guest;
        gcap = guest_cap_of(m_hour);
        ucap = TOTAL - gcap;
        n_uni = m_uni; n_guest = m_guest;
        m_grant = 0; m_deny = 0; m_ack = 0; m_err = 0;
        if (m_ent_rem == 0 && entry_req) begin
            if (entry_is_uni ? (ucap - m_uni > 0) : (gcap - m_guest > 0)) begin
                m_grant = 1; m_ent_rem = OC;
                if (entry_is_uni) n_uni++; else n_guest++;
            end else m_deny = 1;
        end else if (m_ent_rem > 0) m_ent_rem--;
        if (m_ext_rem == 0 && exit_req) begin
            if (exit_is_uni ? (m_uni > 0) : (m_guest > 0)) begin
                m_ack = 1; m_ext_rem = OC;
                if (exit_is_uni) n_uni--; else n_guest--;
            end else m_err = 1;
        end else if (m_ext_rem > 0) m_ext_rem--;
        m_uni = n_uni; m_guest = n_guest; m_hour = int'(hour);
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic idle_cycles(input int n);
        entry_req = 0; exit_req = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        entry_req = 0; exit_req = 0; hour = '0;
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    initial begin
        int hrs[5];
        int caps[5];
        hrs  = '{13, 14, 15, 16, 31};
        caps = '{250, 300, 350, 500, 500};

        // reset state: night split
        #2;
        do_reset();
        check("reset uni_free", 32'(uni_free), 200);
        check("reset guest_free", 32'(guest_free), 500);

        // hour 10 then a single guest entry
        hour = 10;
        step();
        check("day guest_free", 32'(guest_free), 200);
        check("day uni_free", 32'(uni_free), 500);
        entry_req = 1; entry_is_uni = 0;
        step();
        check("first grant", 32'(entry_grant), 1);
        entry_req = 0;
        idle_cycles(5);

        // fill guests to 200, then one more is refused
        entry_req = 1; entry_is_uni = 0;
        for (int i = 0; i < 2000 && m_guest < 200; i++) step();
        check("guests filled", 32'(guest_parked), 200);
        idle_cycles(5);
        entry_req = 1; entry_is_uni = 0;
        step();
        check("full deny", 32'(entry_deny), 1);
        check("full no busy", 32'(entry_busy), 0);
        check("full guest_full", 32'(guest_full), 1);
        step();
        check("held deny again", 32'(entry_deny), 1);

        // simultaneous same-class entry+exit at 200 then at 199
        exit_req = 1; exit_is_uni = 0;
        step();
        check("sim200 deny", 32'(entry_deny), 1);
        check("sim200 ack", 32'(exit_ack), 1);
        check("sim200 count", 32'(guest_parked), 199);
        idle_cycles(5);
        entry_req = 1; entry_is_uni = 0; exit_req = 1; exit_is_uni = 0;
        step();
        check("sim199 grant", 32'(entry_grant), 1);
        check("sim199 ack", 32'(exit_ack), 1);
        check("sim199 count", 32'(guest_parked), 199);
        idle_cycles(5);

        // 300 university cars at hour 10, then shrink uni capacity at hour 20
        entry_req = 1; entry_is_uni = 1;
        for (int i = 0; i < 3000 && m_uni < 300; i++) step();
        check("uni filled", 32'(uni_parked), 300);
        idle_cycles(5);
        hour = 20;
        idle_cycles(2);
        check("night uni_free", 32'(uni_free), -100);
        check("night uni_full", 32'(uni_full), 1);
        entry_req = 1; entry_is_uni = 1;
        step();
        check("night uni deny", 32'(entry_deny), 1);
        hour = 10;
        idle_cycles(2);
        check("day uni_free", 32'(uni_free), 200);
        hour = 20;
        idle_cycles(2);
        exit_req = 1; exit_is_uni = 1;
        step();
        check("night uni ack", 32'(exit_ack), 1);
        check("night uni count", 32'(uni_parked), 299);
        idle_cycles(5);

        // exit of an empty class after reset
        do_reset();
        exit_req = 1; exit_is_uni = 0;
        step();
        check("empty exit err", 32'(exit_err), 1);
        check("empty exit busy", 32'(exit_busy), 0);
        idle_cycles(1);

        // ramp schedule and out-of-range hour
        for (int i = 0; i < 5; i++) begin
            hour = 5'(hrs[i]);
            idle_cycles(2);
            check($sformatf("guest_cap h%0d", hrs[i]), 32'(guest_free), caps[i]);
        end

        // reset while the entry barrier is open
        hour = 10;
        entry_req = 1; entry_is_uni = 0;
        step();
        entry_req = 0;
        step();
        rst_n = 0;
        #1;
        check("rst busy", 32'(entry_busy), 0);
        check("rst guest", 32'(guest_parked), 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        idle_cycles(1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) hour = 5'($urandom_range(0, 31));
            entry_req    = ($urandom_range(0, 3) != 0);
            entry_is_uni = 1'($urandom);
            exit_req     = ($urandom_range(0, 2) == 0);
            exit_is_uni  = 1'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
